// File: rtl/sram_bus_master.sv
// Host-request to SRAM pad-bus initiator: registered bus outputs, read turnaround, optional write-verify.
// Optional feature: define WRITE_VERIFY_EN to read back every write and flag mismatches on verify_err.
module sram_bus_master #(
  parameter int ADDRWIDTH  = 4,
  parameter int DATAWIDTH  = 8,
  parameter int RD_LATENCY = 1,
  parameter int WR_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic                 mem_oe,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 verify_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_TURN  = 3'd4,
    ST_VREAD = 3'd5,
    ST_VWAIT = 3'd6
  } state_t;

  state_t     state_reg;
  logic [2:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 3'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      mem_addr   <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      mem_oe     <= 1'b0;
`ifdef WRITE_VERIFY_EN
      verify_err <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            mem_addr  <= req_addr;
            mem_cs    <= 1'b1;
            if (req_we) begin
              mem_we    <= 1'b1;
              mem_oe    <= 1'b1;
              mem_wdata <= req_wdata;
              cnt_reg   <= 3'(WR_CYCLES - 1);
              state_reg <= ST_WRITE;
            end else begin
              mem_we    <= 1'b0;
              mem_oe    <= 1'b0;
              state_reg <= ST_READ;
            end
          end
        end

        ST_WRITE: begin
          if (cnt_reg == 3'd0) begin
            mem_we <= 1'b0;
            mem_oe <= 1'b0;
`ifdef WRITE_VERIFY_EN
            // Keep cs asserted: the verify read starts on the very next cycle.
            state_reg <= ST_VREAD;
`else
            mem_cs    <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= ST_IDLE;
`endif
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end

        ST_READ: begin
          mem_cs    <= 1'b0;
          cnt_reg   <= 3'(RD_LATENCY - 1);
          state_reg <= ST_RWAIT;
        end

        ST_RWAIT: begin
          if (cnt_reg == 3'd0) begin
            rsp_rdata <= mem_rdata;
            rsp_valid <= 1'b1;
            state_reg <= ST_TURN;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end

        // Bus-idle cycle so the SRAM releases the pads before we may drive them.
        ST_TURN: begin
          req_ready <= 1'b1;
          state_reg <= ST_IDLE;
        end

`ifdef WRITE_VERIFY_EN
        ST_VREAD: begin
          mem_cs    <= 1'b0;
          cnt_reg   <= 3'(RD_LATENCY - 1);
          state_reg <= ST_VWAIT;
        end

        ST_VWAIT: begin
          if (cnt_reg == 3'd0) begin
            if (mem_rdata != mem_wdata) begin
              verify_err <= 1'b1;
            end
            state_reg <= ST_TURN;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
`endif

        default: begin
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          mem_oe    <= 1'b0;
          req_ready <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef WRITE_VERIFY_EN
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bus_master.sv
// Directed bench for sram_bus_master: two instances (RD1/WR1 and RD2/WR2), each with an SRAM pad model.
module tb_sram_bus_master;

  logic       clk;
  logic       rst;
  logic       corrupt_en;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic [3:0] mem_addr  [2];
  logic       mem_cs    [2];
  logic       mem_we    [2];
  logic [7:0] mem_wdata [2];
  logic       mem_oe    [2];
  logic [7:0] mem_rdata [2];
  logic       verify_err[2];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int RDL = (gi == 0) ? 1 : 2;
    localparam int WRC = (gi == 0) ? 1 : 2;

    sram_bus_master #(
      .ADDRWIDTH(4), .DATAWIDTH(8), .RD_LATENCY(RDL), .WR_CYCLES(WRC)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_we(req_we[gi]),
      .req_addr(req_addr[gi]), .req_wdata(req_wdata[gi]),
      .rsp_valid(rsp_valid[gi]), .rsp_rdata(rsp_rdata[gi]),
      .mem_addr(mem_addr[gi]), .mem_cs(mem_cs[gi]), .mem_we(mem_we[gi]),
      .mem_wdata(mem_wdata[gi]), .mem_oe(mem_oe[gi]), .mem_rdata(mem_rdata[gi]),
      .verify_err(verify_err[gi])
    );

    // SRAM model: data appears RDL cycles after the edge closing the cs read cycle, X otherwise.
    logic [7:0] sram [16];
    logic [7:0] pipe [RDL];
    always @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < 16; k++) sram[k] <= 8'h30 + 8'(k);
        for (int k = 0; k < RDL; k++) pipe[k] <= 8'hxx;
      end else begin
        if (mem_cs[gi] && mem_we[gi])
          sram[mem_addr[gi]] <= (gi == 0 && corrupt_en && mem_addr[gi] == 4'h7) ?
                                (mem_wdata[gi] ^ 8'h01) : mem_wdata[gi];
        pipe[0] <= (mem_cs[gi] && !mem_we[gi]) ? sram[mem_addr[gi]] : 8'hxx;
        for (int k = 1; k < RDL; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign mem_rdata[gi] = pipe[RDL-1];

    int   wcs_cnt = 0;
    int   oe_bad  = 0;
    int   oe_cnt  = 0;
    int   rsp_cnt = 0;
    int   viol    = 0;
    logic prev_drv = 1'b0;
    always @(negedge clk) begin
      if (!rst) begin
        if (mem_cs[gi] && mem_we[gi]) wcs_cnt++;
        if (mem_oe[gi] && !(mem_cs[gi] && mem_we[gi])) oe_bad++;
        if (mem_oe[gi]) oe_cnt++;
        if (rsp_valid[gi]) rsp_cnt++;
        if (mem_oe[gi] && ((mem_cs[gi] && !mem_we[gi]) || prev_drv)) viol++;
        prev_drv = mem_cs[gi] && !mem_we[gi];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    req_we[i] = we; req_addr[i] = a; req_wdata[i] = d; req_valid[i] = 1'b1;
    while (req_ready[i] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("accept_timeout", 32'(req_ready[i]), 32'd1);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic do_write(input int i, input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    issue(i, 1'b1, a, d);
    while (req_ready[i] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("write_done_timeout", 32'(req_ready[i]), 32'd1);
  endtask

  task automatic do_read(input int i, input logic [3:0] a, input logic [7:0] exp,
                         input int lat, input string tag);
    int c;
    c = 1;
    issue(i, 1'b0, a, 8'h00);
    while (rsp_valid[i] !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    chk({tag, "_lat"}, 32'(c), 32'(2 + lat));
    chk({tag, "_data"}, 32'(rsp_rdata[i]), 32'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rsp_valid[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2;
    rst = 1'b1;
    corrupt_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 4'h0; req_wdata[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready[0]), 32'd1);
    chk("idle_cs", 32'(mem_cs[0]), 32'd0);

    // Test 1: reset asserted in the middle of a write cycle
    issue(0, 1'b1, 4'hA, 8'h11);
    chk("t1_cs_before", 32'(mem_cs[0]), 32'd1);
    chk("t1_oe_before", 32'(mem_oe[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_oe", 32'(mem_oe[0]), 32'd0);
    chk("t1_cs", 32'(mem_cs[0]), 32'd0);
    chk("t1_we", 32'(mem_we[0]), 32'd0);
    chk("t1_ready", 32'(req_ready[0]), 32'd1);
    chk("t1_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("t1_rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
    chk("t1_addr", 32'(mem_addr[0]), 32'd0);
    chk("t1_wdata", 32'(mem_wdata[0]), 32'd0);
    chk("t1_verr", 32'(verify_err[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", 32'(req_ready[0]), 32'd1);
    chk("t1_mem_untouched", 32'(g_dut[0].sram[4'hA]), 32'h3A);

    // Test 2: single write, one cs/we cycle, oe only alongside it
    s0 = g_dut[0].wcs_cnt; s1 = g_dut[0].oe_bad; s2 = g_dut[0].rsp_cnt;
    do_write(0, 4'hA, 8'h5C);
    repeat (2) @(negedge clk);
    chk("t2_wcs_cycles", 32'(g_dut[0].wcs_cnt - s0), 32'd1);
    chk("t2_oe_outside", 32'(g_dut[0].oe_bad - s1), 32'd0);
    chk("t2_no_rsp", 32'(g_dut[0].rsp_cnt - s2), 32'd0);
    chk("t2_mem", 32'(g_dut[0].sram[4'hA]), 32'h5C);

    // Test 3: read back, oe never asserted
    s0 = g_dut[0].oe_cnt;
    do_read(0, 4'hA, 8'h5C, 1, "t3_rd_A");
    chk("t3_oe_cycles", 32'(g_dut[0].oe_cnt - s0), 32'd0);

    // Test 4: read then held write request -> TURN before the write drives
    issue(0, 1'b0, 4'h3, 8'h00);
    chk("t4_c1_cs", 32'(mem_cs[0]), 32'd1);
    chk("t4_c1_we", 32'(mem_we[0]), 32'd0);
    chk("t4_c1_oe", 32'(mem_oe[0]), 32'd0);
    req_we[0] = 1'b1; req_addr[0] = 4'h3; req_wdata[0] = 8'hFF; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t4_c2_cs", 32'(mem_cs[0]), 32'd0);
    chk("t4_c2_oe", 32'(mem_oe[0]), 32'd0);
    chk("t4_c2_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    chk("t4_turn_rsp", 32'(rsp_valid[0]), 32'd1);
    chk("t4_turn_data", 32'(rsp_rdata[0]), 32'h33);
    chk("t4_turn_cs", 32'(mem_cs[0]), 32'd0);
    chk("t4_turn_oe", 32'(mem_oe[0]), 32'd0);
    @(negedge clk);
    chk("t4_idle_ready", 32'(req_ready[0]), 32'd1);
    chk("t4_idle_oe", 32'(mem_oe[0]), 32'd0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("t4_wr_cs", 32'(mem_cs[0]), 32'd1);
    chk("t4_wr_we", 32'(mem_we[0]), 32'd1);
    chk("t4_wr_oe", 32'(mem_oe[0]), 32'd1);
    chk("t4_wr_wdata", 32'(mem_wdata[0]), 32'hFF);
    s0 = 0;
    while (req_ready[0] !== 1'b1 && s0 < 40) begin @(negedge clk); s0++; end
    chk("t4_wr_done", 32'(req_ready[0]), 32'd1);
    do_read(0, 4'h3, 8'hFF, 1, "t4_rd_3");

    // Test 6: write-verify (sticky error with macro, always clear without)
    s2 = g_dut[0].rsp_cnt;
    do_write(0, 4'h5, 8'h99);
    repeat (2) @(negedge clk);
    chk("t6_clean_verr", 32'(verify_err[0]), 32'd0);
    corrupt_en = 1'b1;
    do_write(0, 4'h7, 8'h80);
    repeat (2) @(negedge clk);
    corrupt_en = 1'b0;
    chk("t6_mem_corrupt", 32'(g_dut[0].sram[4'h7]), 32'h81);
`ifdef WRITE_VERIFY_EN
    chk("t6_verr_set", 32'(verify_err[0]), 32'd1);
`else
    chk("t6_verr_tied", 32'(verify_err[0]), 32'd0);
`endif
    do_write(0, 4'h8, 8'h42);
    repeat (2) @(negedge clk);
`ifdef WRITE_VERIFY_EN
    chk("t6_verr_sticky", 32'(verify_err[0]), 32'd1);
`else
    chk("t6_verr_still0", 32'(verify_err[0]), 32'd0);
`endif
    chk("t6_no_rsp", 32'(g_dut[0].rsp_cnt - s2), 32'd0);

    // Test 5: full sweep on the RD_LATENCY=2 / WR_CYCLES=2 instance
    for (int a = 0; a < 16; a++) do_write(1, 4'(a), ~{4'h0, 4'(a)});
    for (int a = 0; a < 16; a++) do_read(1, 4'(a), ~{4'h0, 4'(a)}, 2, $sformatf("t5_rd_%0h", a));

    chk("contention_0", 32'(g_dut[0].viol), 32'd0);
    chk("contention_1", 32'(g_dut[1].viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
